dm_ctrl: RTL and testbench

- Parametrised next-generation data memory for the single-cycle/multi-cycle MIPS datapath.
- Adds byte/halfword/word accesses with load sign/zero extension and misalignment detection.
- Uses a req/ready handshake with configurable wait states to model slower memory.
- Zeroes the array after reset using a clear sweep instead of a one-cycle for-loop reset.
- Sits between the ALU result/rt read port and the writeback mux.

---
 rtl/dm_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dm_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// dm_ctrl: data memory with byte/half/word access, req/ready handshake,
// configurable wait states and a post-reset clear sweep.
//
// Ports:
//   dmc_clk       in   clock, rising edge
//   dmc_reset     in   async active-low reset
//   dmc_pc[31:0]  in   requesting PC (write trace only)
//   dmc_req       in   access request, held until dmc_ready
//   dmc_we        in   1 = store, 0 = load
//   dmc_size[1:0] in   00 byte, 01 half, 10 word, 11 illegal
//   dmc_unsigned  in   1 = zero-extend loads
//   dmc_addr[31:0] in  byte address
//   dmc_wdata[31:0] in right-aligned store data
//   dmc_ready     out  one-cycle completion pulse
//   dmc_rdata[31:0] out registered load result
//   dmc_misalign  out  error flag for the completing access
//   dmc_busy      out  high while the array is being cleared
module dm_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int WAIT           = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        dmc_clk,
  input  logic        dmc_reset,
  input  logic [31:0] dmc_pc,
  input  logic        dmc_req,
  input  logic        dmc_we,
  input  logic [1:0]  dmc_size,
  input  logic        dmc_unsigned,
  input  logic [31:0] dmc_addr,
  input  logic [31:0] dmc_wdata,
  output logic        dmc_ready,
  output logic [31:0] dmc_rdata,
  output logic        dmc_misalign,
  output logic        dmc_busy
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LD =
    (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam state_t RST_STATE =
    CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_clr_cnt;
  logic [3:0]        r_wait_cnt;
  logic [31:0]       r_pc;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic              r_uns;
  logic [1:0]        r_size;
  logic [31:0]       r_rdata;
  logic              r_mis;
  logic [31:0]       r_mem [DEPTH];

  logic              w_sel_in;
  logic [31:0]       w_pc;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic              w_we;
  logic              w_uns;
  logic [1:0]        w_size;
  logic              w_cap;
  logic              w_go;
  logic              w_wr;
  logic              w_mis;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_word;
  logic [7:0]        w_b;
  logic [15:0]       w_h;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  // With WAIT=0 the access happens on the capture edge itself,
  // so the datapath reads the live inputs while in IDLE.
  assign w_sel_in = (r_state == S_IDLE);
  assign w_pc     = w_sel_in ? dmc_pc       : r_pc;
  assign w_addr   = w_sel_in ? dmc_addr     : r_addr;
  assign w_wdata  = w_sel_in ? dmc_wdata    : r_wdata;
  assign w_we     = w_sel_in ? dmc_we       : r_we;
  assign w_uns    = w_sel_in ? dmc_unsigned : r_uns;
  assign w_size   = w_sel_in ? dmc_size     : r_size;

  assign w_cap  = (r_state == S_IDLE) && dmc_req;
  assign w_go   = (w_next == S_RESP);
  assign w_idx  = w_addr[ADDR_W+1:2];
  assign w_word = r_mem[w_idx];
  assign w_wr   = w_go && w_we && !w_mis;

  assign w_b = w_word[{w_addr[1:0], 3'b000} +: 8];
  assign w_h = w_word[{w_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_mis = 1'b0;
    unique case (w_size)
      2'b00: w_mis = 1'b0;
      2'b01: w_mis = w_addr[0];
      2'b10: w_mis = |w_addr[1:0];
      2'b11: w_mis = 1'b1;
    endcase
  end

  always_comb begin
    w_load = w_word;
    unique case (w_size)
      2'b00: w_load = {{24{~w_uns & w_b[7]}}, w_b};
      2'b01: w_load = {{16{~w_uns & w_h[15]}}, w_h};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    w_merged = w_word;
    unique case (w_size)
      2'b00: w_merged[{w_addr[1:0], 3'b000} +: 8] = w_wdata[7:0];
      2'b01: w_merged[{w_addr[1], 4'b0000} +: 16] = w_wdata[15:0];
      default: w_merged = w_wdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CLEAR: if (&r_clr_cnt) w_next = S_IDLE;
      S_IDLE:  if (dmc_req) w_next = (WAIT == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_wait_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge dmc_clk or negedge dmc_reset) begin
    if (!dmc_reset) begin
      r_state    <= RST_STATE;
      r_clr_cnt  <= '0;
      r_wait_cnt <= '0;
      r_pc       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= 2'b00;
      r_rdata    <= '0;
      r_mis      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_cap) begin
        r_pc       <= dmc_pc;
        r_addr     <= dmc_addr;
        r_wdata    <= dmc_wdata;
        r_we       <= dmc_we;
        r_uns      <= dmc_unsigned;
        r_size     <= dmc_size;
        r_wait_cnt <= WAIT_LD;
      end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_go) begin
        r_mis <= w_mis;
        // Stores leave the last load result in place.
        if (w_mis)      r_rdata <= '0;
        else if (!w_we) r_rdata <= w_load;
      end
    end
  end

  // The array carries no reset; it is zeroed by the clear sweep.
  always_ff @(posedge dmc_clk) begin
    if (r_state == S_CLEAR) r_mem[r_clr_cnt] <= '0;
    else if (w_wr)          r_mem[w_idx]     <= w_merged;
  end

`ifndef SYNTHESIS
  always_ff @(posedge dmc_clk) begin
    if (r_state != S_CLEAR && w_wr)
      $display("@%h:*%h<=%h", w_pc, w_addr, w_merged);
  end
`endif

  assign dmc_ready    = (r_state == S_RESP);
  assign dmc_rdata    = r_rdata;
  assign dmc_misalign = r_mis;
  assign dmc_busy     = (r_state == S_CLEAR);

endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: two dm_ctrl instances (WAIT=0 with clear, WAIT=3 without)
// checked against a byte-addressed memory model.
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req   [2];
  logic        we    [2];
  logic        uns   [2];
  logic [1:0]  sz    [2];
  logic [31:0] pc    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        mis   [2];
  logic        busy  [2];

  logic [7:0]  mb [2][64];

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dm_ctrl #(.ADDR_W(4), .WAIT(0), .CLEAR_ON_RESET(1'b1)) u0 (
    .dmc_clk(clk), .dmc_reset(rst_n[0]), .dmc_pc(pc[0]),
    .dmc_req(req[0]), .dmc_we(we[0]), .dmc_size(sz[0]),
    .dmc_unsigned(uns[0]), .dmc_addr(addr[0]), .dmc_wdata(wd[0]),
    .dmc_ready(rdy[0]), .dmc_rdata(rdata[0]),
    .dmc_misalign(mis[0]), .dmc_busy(busy[0])
  );

  dm_ctrl #(.ADDR_W(4), .WAIT(3), .CLEAR_ON_RESET(1'b0)) u1 (
    .dmc_clk(clk), .dmc_reset(rst_n[1]), .dmc_pc(pc[1]),
    .dmc_req(req[1]), .dmc_we(we[1]), .dmc_size(sz[1]),
    .dmc_unsigned(uns[1]), .dmc_addr(addr[1]), .dmc_wdata(wd[1]),
    .dmc_ready(rdy[1]), .dmc_rdata(rdata[1]),
    .dmc_misalign(mis[1]), .dmc_busy(busy[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Byte-level reference: 64 bytes per instance, little-endian.
  function automatic void mdl(
    input int d, input bit w, input logic [1:0] s, input bit u,
    input logic [31:0] a, input logic [31:0] data,
    output logic [31:0] r, output logic m
  );
    int n;
    int base;
    n = 1 << s;
    base = int'(a % 64);
    m = (s == 2'b11) || ((a % n) != 0);
    r = '0;
    if (!m) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[d][base + i] = data[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) r = r | (32'(mb[d][base + i]) << (8*i));
        if (n < 4 && !u && r[8*n-1]) r = r | (32'hFFFF_FFFF << (8*n));
      end
    end
  endfunction

  // Starts and ends on a negedge with the DUT in IDLE.
  task automatic acc(
    input int d, input bit w, input logic [1:0] s, input bit u,
    input logic [31:0] a, input logic [31:0] data,
    output logic [31:0] r, output logic m, output int lat
  );
    req[d] = 1'b1; we[d] = w; sz[d] = s; uns[d] = u;
    addr[d] = a; wd[d] = data; pc[d] = $urandom;
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
    end while (!rdy[d] && lat < 40);
    r = rdata[d];
    m = mis[d];
    req[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; sz[d] = 2'b00;
      uns[d] = 1'b0; addr[d] = '0; wd[d] = '0; pc[d] = '0;
      for (int i = 0; i < 64; i++) mb[d][i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tot++;
      if (rdy[d] !== 1'b0) begin
        bad++; $display("FAIL reset_ready d=%0d got=%b exp=0", d, rdy[d]);
      end
      tot++;
      if (rdata[d] !== 32'h0) begin
        bad++; $display("FAIL reset_rdata d=%0d got=%h exp=0", d, rdata[d]);
      end
      tot++;
      if (mis[d] !== 1'b0) begin
        bad++; $display("FAIL reset_mis d=%0d got=%b exp=0", d, mis[d]);
      end
    end
    tot++;
    if (busy[0] !== 1'b1) begin
      bad++; $display("FAIL reset_busy0 got=%b exp=1", busy[0]);
    end
    tot++;
    if (busy[1] !== 1'b0) begin
      bad++; $display("FAIL reset_busy1 got=%b exp=0", busy[1]);
    end
  endtask

  task automatic test_clear();
    int nbusy;
    int lat;
    int early;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    req[0] = 1'b1; we[0] = 1'b0; sz[0] = 2'b10; addr[0] = 32'h3C;
    #1;
    nbusy = busy[0] ? 1 : 0;
    early = 0;
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (busy[0]) nbusy++;
      if (busy[0] && rdy[0]) early++;
    end while (!rdy[0] && lat < 60);
    tot++;
    if (nbusy != 16) begin
      bad++; $display("FAIL clear_busy_len got=%0d exp=16", nbusy);
    end
    tot++;
    if (early != 0) begin
      bad++; $display("FAIL clear_ready_in_busy got=%0d exp=0", early);
    end
    tot++;
    if (lat != 17) begin
      bad++; $display("FAIL clear_req_latency got=%0d exp=17", lat);
    end
    tot++;
    if (rdata[0] !== 32'h0 || mis[0] !== 1'b0) begin
      bad++;
      $display("FAIL clear_read3c got=%h/%b exp=0/0", rdata[0], mis[0]);
    end
    req[0] = 1'b0;
    @(negedge clk);
    tot++;
    if (busy[1] !== 1'b0) begin
      bad++; $display("FAIL clear_busy1 got=%b exp=0", busy[1]);
    end
  endtask

  task automatic test_word();
    logic [31:0] r, er;
    logic m, em;
    int lat;
    mdl(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, er, em);
    acc(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, r, m, lat);
    tot++;
    if (lat != 1 || m !== 1'b0) begin
      bad++; $display("FAIL word_store lat=%0d mis=%b exp=1/0", lat, m);
    end
    acc(0, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, r, m, lat);
    tot++;
    if (r !== 32'h12345678 || lat != 1) begin
      bad++; $display("FAIL word_load got=%h lat=%0d exp=12345678/1", r, lat);
    end
  endtask

  task automatic test_subword();
    logic [31:0] r, er;
    logic m, em;
    int lat;
    logic [31:0] exp_v [4];
    logic [31:0] la [4];
    logic [1:0]  ls [4];
    logic        lu [4];
    exp_v = '{32'hFFFFFFAB, 32'h000000AB, 32'hFFFFBEEF, 32'h0000BEEF};
    la    = '{32'h11, 32'h11, 32'h12, 32'h12};
    ls    = '{2'b00, 2'b00, 2'b01, 2'b01};
    lu    = '{1'b0, 1'b1, 1'b0, 1'b1};
    mdl(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAB, er, em);
    acc(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAB, r, m, lat);
    acc(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r, m, lat);
    tot++;
    if (r !== 32'h1234AB78) begin
      bad++; $display("FAIL sb_merge got=%h exp=1234ab78", r);
    end
    mdl(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, er, em);
    acc(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, r, m, lat);
    acc(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r, m, lat);
    tot++;
    if (r !== 32'hBEEFAB78) begin
      bad++; $display("FAIL sh_merge got=%h exp=beefab78", r);
    end
    for (int i = 0; i < 4; i++) begin
      acc(0, 1'b0, ls[i], lu[i], la[i], 32'h0, r, m, lat);
      tot++;
      if (r !== exp_v[i] || m !== 1'b0) begin
        bad++; $display("FAIL subload_%0d got=%h exp=%h", i, r, exp_v[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] r;
    logic m;
    int lat;
    logic        mw [3];
    logic [1:0]  ms [3];
    logic [31:0] ma [3];
    mw = '{1'b1, 1'b1, 1'b0};
    ms = '{2'b01, 2'b10, 2'b11};
    ma = '{32'h13, 32'h16, 32'h10};
    for (int i = 0; i < 3; i++) begin
      acc(0, mw[i], ms[i], 1'b1, ma[i], 32'h22221111, r, m, lat);
      tot++;
      if (m !== 1'b1 || r !== 32'h0 || lat != 1) begin
        bad++;
        $display("FAIL misalign_%0d mis=%b rd=%h lat=%0d exp=1/0/1",
                 i, m, r, lat);
      end
    end
    acc(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r, m, lat);
    tot++;
    if (r !== 32'hBEEFAB78) begin
      bad++; $display("FAIL misalign_nowrite got=%h exp=beefab78", r);
    end
    acc(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, r, m, lat);
    tot++;
    if (r !== 32'h0) begin
      bad++; $display("FAIL misalign_nowrite14 got=%h exp=0", r);
    end
  endtask

  task automatic test_back_to_back(input int d);
    logic [31:0] er;
    logic em;
    int p;
    bit exp_rdy;
    p = 2 + wait_of(d);
    mdl(d, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, er, em);
    req[d] = 1'b1; we[d] = 1'b0; sz[d] = 2'b10;
    uns[d] = 1'b0; addr[d] = 32'h10;
    for (int k = 1; k <= 4 * p; k++) begin
      @(posedge clk); @(negedge clk);
      exp_rdy = ((k % p) == (p - 1));
      tot++;
      if (rdy[d] !== exp_rdy) begin
        bad++;
        $display("FAIL b2b_ready d=%0d k=%0d got=%b exp=%b",
                 d, k, rdy[d], exp_rdy);
      end else if (exp_rdy && rdata[d] !== er) begin
        bad++;
        $display("FAIL b2b_data d=%0d got=%h exp=%h", d, rdata[d], er);
      end
    end
    req[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] r, er;
    logic m, em;
    int lat;
    mdl(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, er, em);
    acc(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, r, m, lat);
    acc(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, r, m, lat);
    tot++;
    if (r !== 32'hCAFEF00D) begin
      bad++; $display("FAIL wrap got=%h exp=cafef00d", r);
    end
  endtask

  task automatic test_wait();
    logic [31:0] r, er, v;
    logic m, em;
    int lat;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      mdl(1, 1'b1, 2'b10, 1'b0, 32'(i * 4), v, er, em);
      acc(1, 1'b1, 2'b10, 1'b0, 32'(i * 4), v, r, m, lat);
      tot++;
      if (lat != 4 || m !== 1'b0) begin
        bad++; $display("FAIL wait_store lat=%0d mis=%b exp=4/0", lat, m);
      end
    end
    acc(1, 1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, r, m, lat);
    mdl(1, 1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, er, em);
    tot++;
    if (r !== er || lat != 4) begin
      bad++; $display("FAIL wait_load got=%h lat=%0d exp=%h/4", r, lat, er);
    end
  endtask

  task automatic test_random(input int d, input int n);
    logic [31:0] r, er, a, v;
    logic m, em;
    logic [1:0] s;
    bit w, u;
    int lat;
    for (int i = 0; i < n; i++) begin
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      v = $urandom;
      if ($urandom_range(0, 3) != 0 && s != 2'b11)
        a = a & ~(32'(1 << s) - 32'd1);
      mdl(d, w, s, u, a, v, er, em);
      acc(d, w, s, u, a, v, r, m, lat);
      tot++;
      if (lat != 1 + wait_of(d) || m !== em ||
          ((!w || em) && r !== er)) begin
        bad++;
        $display("FAIL rand d=%0d a=%h s=%0d we=%0d got=%h/%b/%0d exp=%h/%b/%0d",
                 d, a, s, w, r, m, lat, er, em, 1 + wait_of(d));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, er;
    logic m, em;
    int lat;
    mdl(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h5A5A0001, er, em);
    acc(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h5A5A0001, r, m, lat);
    acc(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, r, m, lat);
    tot++;
    if (r !== 32'h5A5A0001) begin
      bad++; $display("FAIL rmid_pre got=%h exp=5a5a0001", r);
    end
    req[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'b10;
    addr[1] = 32'h20; wd[1] = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    rst_n[1] = 1'b0;
    req[1] = 1'b0;
    #1;
    tot++;
    if (rdy[1] !== 1'b0 || rdata[1] !== 32'h0 ||
        mis[1] !== 1'b0 || busy[1] !== 1'b0) begin
      bad++;
      $display("FAIL rmid_outs got=%b/%h/%b/%b exp=0/0/0/0",
               rdy[1], rdata[1], mis[1], busy[1]);
    end
    @(posedge clk); @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (4) @(negedge clk);
    acc(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, r, m, lat);
    tot++;
    if (r !== 32'h5A5A0001 || lat != 4) begin
      bad++; $display("FAIL rmid_kept got=%h lat=%0d exp=5a5a0001/4", r, lat);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_word();
    test_subword();
    test_misalign();
    test_back_to_back(0);
    test_wrap();
    test_wait();
    test_back_to_back(1);
    test_random(0, 40);
    test_random(1, 30);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
